// File: rtl/alu_sru_sequencer_pkg.sv
// Shared ALU shift/rotate definitions: mode codes, sequencer state encodings.
// Pure definitions, no timing.
// Imported by the sequencer, its step datapath and the microcode assembler tables.
package alu_sru_sequencer_pkg;

  // Sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Shift/rotate mode codes carried in ir[6:4]; 101-111 are reserved
  typedef enum logic [2:0] {
    MODE_SHL = 3'b000,
    MODE_SHR = 3'b001,
    MODE_ASR = 3'b010,
    MODE_ROL = 3'b011,
    MODE_ROR = 3'b100
  } mode_t;

  localparam int unsigned IR_MODE_LSB = 4;
  localparam int unsigned IR_CNT_LSB  = 0;

  // True for the five defined shift/rotate modes
  function automatic logic mode_is_valid(input logic [2:0] code);
    return (code <= 3'b100);
  endfunction

endpackage

// File: rtl/alu_sru_step.sv
// One combinational 1-bit shift/rotate step on the {L,B} pair.
// Latency: zero (pure combinational).
// No flow control; the sequencer decides when the result is registered.
module alu_sru_step
  import alu_sru_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             l,
  input  logic [WIDTH-1:0] b,
  input  mode_t            mode,
  output logic             l_next,
  output logic [WIDTH-1:0] b_next
);

  // Select the next {L,B} for the current mode; reserved modes hold the value
  always_comb begin
    l_next = l;
    b_next = b;
    case (mode)
      MODE_SHL: begin
        l_next = b[WIDTH-1];
        b_next = {b[WIDTH-2:0], 1'b0};
      end
      MODE_SHR: begin
        l_next = b[0];
        b_next = {1'b0, b[WIDTH-1:1]};
      end
      MODE_ASR: begin
        l_next = b[0];
        b_next = {b[WIDTH-1], b[WIDTH-1:1]};
      end
      MODE_ROL: begin
        // {L,B} rotated left: L takes B's msb, old L enters B's lsb
        l_next = b[WIDTH-1];
        b_next = {b[WIDTH-2:0], l};
      end
      MODE_ROR: begin
        // {L,B} rotated right: L takes B's lsb, old L enters B's msb
        l_next = b[0];
        b_next = {l, b[WIDTH-1:1]};
      end
      default: begin
        l_next = l;
        b_next = b;
      end
    endcase
  end

endmodule

// File: rtl/alu_sru_sequencer.sv
// ALU B register, link flag L, and a multi-cycle shift/rotate sequencer.
// Latency: a count of N takes N SHIFT cycles plus one DONE cycle.
// nstall is held low while shifting; bus commands are ignored until back in IDLE.
module alu_sru_sequencer
  import alu_sru_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4
) (
  input  logic             clk4,
  input  logic             nreset,
  input  logic             nwrite_alu_b,
  input  logic             nread_alu_b,
  input  logic             naction_cpl,
  input  logic             naction_cll,
  input  logic             naction_sru,
  input  logic [7:0]       ir,
  inout  wire  [WIDTH-1:0] ibus,
  output logic             fl,
  output logic             nstall,
  output logic             ndone
);

  state_t           state;
  mode_t            mode;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] b;
  logic             l;
  logic             l_step;
  logic [WIDTH-1:0] b_step;

  logic [2:0]       ir_mode;
  logic [CNTW-1:0]  ir_cnt;
  logic             sru_ok;

  assign ir_mode = ir[IR_MODE_LSB +: 3];
  assign ir_cnt  = ir[IR_CNT_LSB +: CNTW];
  // A shift only starts with a nonzero count and a defined mode
  assign sru_ok  = (ir_cnt != '0) && mode_is_valid(ir_mode);

  alu_sru_step #(.WIDTH(WIDTH)) u_step (
    .l      (l),
    .b      (b),
    .mode   (mode),
    .l_next (l_step),
    .b_next (b_step)
  );

  // B is visible on the bus whenever it is read, in every state
  assign ibus = (!nread_alu_b) ? b : {WIDTH{1'bz}};
  assign fl   = l;

  // Sequencer FSM with registered handshake outputs
  always_ff @(posedge clk4 or negedge nreset) begin
    if (!nreset) begin
      state  <= ST_IDLE;
      mode   <= MODE_SHL;
      cnt    <= '0;
      b      <= '0;
      l      <= 1'b0;
      nstall <= 1'b1;
      ndone  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          ndone <= 1'b1;
          if (!nwrite_alu_b) begin
            b <= ibus;
          end
          if (!naction_cll) begin
            l <= 1'b0;
          end else if (!naction_cpl) begin
            l <= ~l;
          end
          // A same-cycle write discards the shift request
          if (!naction_sru && nwrite_alu_b && sru_ok) begin
            mode   <= mode_t'(ir_mode);
            cnt    <= ir_cnt;
            state  <= ST_SHIFT;
            nstall <= 1'b0;
          end
        end
        ST_SHIFT: begin
          b   <= b_step;
          l   <= l_step;
          cnt <= cnt - 1'b1;
          if (cnt == CNTW'(1)) begin
            state  <= ST_DONE;
            nstall <= 1'b1;
            ndone  <= 1'b0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          ndone <= 1'b1;
        end
        default: begin
          state  <= ST_IDLE;
          nstall <= 1'b1;
          ndone  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sru_sequencer.sv
module tb_alu_sru_sequencer;

  logic        clk4 = 1'b0;
  logic        nreset;
  logic        nwrite_alu_b;
  logic        nread_alu_b;
  logic        naction_cpl;
  logic        naction_cll;
  logic        naction_sru;
  logic [7:0]  ir;
  wire  [15:0] ibus;
  logic        fl;
  logic        nstall;
  logic        ndone;

  logic        drv_en;
  logic [15:0] drv_val;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] b;
    logic        l;
    int          stalls;
  } exp_t;

  exp_t sb[$];

  assign ibus = drv_en ? drv_val : 16'hzzzz;

  always #5 clk4 = ~clk4;

  alu_sru_sequencer #(.WIDTH(16), .CNTW(4)) dut (
    .clk4         (clk4),
    .nreset       (nreset),
    .nwrite_alu_b (nwrite_alu_b),
    .nread_alu_b  (nread_alu_b),
    .naction_cpl  (naction_cpl),
    .naction_cll  (naction_cll),
    .naction_sru  (naction_sru),
    .ir           (ir),
    .ibus         (ibus),
    .fl           (fl),
    .nstall       (nstall),
    .ndone        (ndone)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one cycle: inputs change and outputs are sampled at the falling edge
  task automatic tick();
    @(posedge clk4);
    @(negedge clk4);
  endtask

  task automatic write_b(input logic [15:0] v);
    drv_en = 1'b1; drv_val = v; nwrite_alu_b = 1'b0;
    tick();
    nwrite_alu_b = 1'b1; drv_en = 1'b0;
  endtask

  task automatic read_b(output logic [15:0] v);
    nread_alu_b = 1'b0;
    #1 v = ibus;
    nread_alu_b = 1'b1;
    #1;
  endtask

  task automatic set_l(input logic v);
    naction_cll = 1'b0;
    tick();
    naction_cll = 1'b1;
    if (v) begin
      naction_cpl = 1'b0;
      tick();
      naction_cpl = 1'b1;
    end
  endtask

  // Issue a shift, count stall cycles, compare against the scoreboard at ndone
  task automatic run_shift(input string tag, input logic [7:0] ir_v,
                           input logic [15:0] eb, input logic el, input int n);
    exp_t e;
    exp_t got;
    int   stalls;
    bit   seen;
    logic [15:0] rb;
    e.b = eb; e.l = el; e.stalls = n;
    sb.push_back(e);
    ir = ir_v; naction_sru = 1'b0;
    tick();
    naction_sru = 1'b1;
    stalls = 0; seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (ndone === 1'b0) begin seen = 1; break; end
      if (nstall === 1'b0) stalls++;
      tick();
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    got = sb.pop_front();
    read_b(rb);
    chk({tag, "_b"}, {16'd0, rb}, {16'd0, got.b});
    chk({tag, "_l"}, {31'd0, fl}, {31'd0, got.l});
    chk({tag, "_stalls"}, stalls, got.stalls);
    chk({tag, "_nstall_done"}, {31'd0, nstall}, 32'd1);
    tick();
    chk({tag, "_ndone_idle"}, {31'd0, ndone}, 32'd1);
  endtask

  // A shift request that must be refused: no stall, no done, B/L unchanged
  task automatic no_shift(input string tag, input logic [7:0] ir_v,
                          input logic [15:0] eb, input logic el);
    logic [15:0] rb;
    ir = ir_v; naction_sru = 1'b0;
    tick();
    naction_sru = 1'b1;
    chk({tag, "_nstall"}, {31'd0, nstall}, 32'd1);
    chk({tag, "_ndone"}, {31'd0, ndone}, 32'd1);
    tick();
    chk({tag, "_nstall2"}, {31'd0, nstall}, 32'd1);
    chk({tag, "_ndone2"}, {31'd0, ndone}, 32'd1);
    read_b(rb);
    chk({tag, "_b"}, {16'd0, rb}, {16'd0, eb});
    chk({tag, "_l"}, {31'd0, fl}, {31'd0, el});
  endtask

  initial begin
    logic [15:0] rb;
    int          stalls;
    exp_t        e;
    exp_t        got;

    nreset = 1'b0; nwrite_alu_b = 1'b1; nread_alu_b = 1'b1;
    naction_cpl = 1'b1; naction_cll = 1'b1; naction_sru = 1'b1;
    ir = 8'h00; drv_en = 1'b0; drv_val = 16'h0000;

    // Reset state
    repeat (2) tick();
    read_b(rb);
    chk("rst_b", {16'd0, rb}, 32'h0);
    chk("rst_fl", {31'd0, fl}, 32'd0);
    chk("rst_nstall", {31'd0, nstall}, 32'd1);
    chk("rst_ndone", {31'd0, ndone}, 32'd1);
    nreset = 1'b1;

    // SHL by 1 on the first edges after reset release
    write_b(16'h8001);
    set_l(1'b0);
    run_shift("shl1", 8'h01, 16'h0002, 1'b1, 1);

    // ROR by 4
    write_b(16'h000F);
    set_l(1'b0);
    run_shift("ror4", 8'h44, 16'hE000, 1'b1, 4);

    // SHR, ROL, ROL wrapping L back into B
    write_b(16'h0001);
    set_l(1'b0);
    run_shift("shr1", 8'h11, 16'h0000, 1'b1, 1);
    write_b(16'h8000);
    set_l(1'b0);
    run_shift("rol1a", 8'h31, 16'h0000, 1'b1, 1);
    run_shift("rol1b", 8'h31, 16'h0001, 1'b0, 1);

    // Count 0 and reserved mode are refused
    write_b(16'h1234);
    set_l(1'b1);
    no_shift("cnt0", 8'h00, 16'h1234, 1'b1);
    no_shift("rsvd", 8'h53, 16'h1234, 1'b1);

    // Write and shift in the same cycle: write wins
    drv_en = 1'b1; drv_val = 16'hAAAA; nwrite_alu_b = 1'b0;
    ir = 8'h01; naction_sru = 1'b0;
    tick();
    nwrite_alu_b = 1'b1; naction_sru = 1'b1; drv_en = 1'b0;
    chk("wr_sru_nstall", {31'd0, nstall}, 32'd1);
    read_b(rb);
    chk("wr_sru_b", {16'd0, rb}, 32'h0000AAAA);

    // cpl and cll together: cll wins
    chk("cpl_pre_l", {31'd0, fl}, 32'd1);
    naction_cpl = 1'b0; naction_cll = 1'b0;
    tick();
    naction_cpl = 1'b1; naction_cll = 1'b1;
    chk("cpl_cll_l", {31'd0, fl}, 32'd0);
    naction_cpl = 1'b0;
    tick();
    naction_cpl = 1'b1;
    chk("cpl_only_l", {31'd0, fl}, 32'd1);

    // ASR by 15 aborted by reset at stall cycle 7
    write_b(16'h8000);
    set_l(1'b0);
    ir = 8'h2F; naction_sru = 1'b0;
    tick();
    naction_sru = 1'b1;
    stalls = 0;
    for (int c = 0; c < 40; c++) begin
      if (nstall === 1'b0) stalls++;
      if (stalls == 7) break;
      tick();
    end
    chk("abort_stalls", stalls, 7);
    nreset = 1'b0;
    #1;
    chk("abort_nstall", {31'd0, nstall}, 32'd1);
    chk("abort_fl", {31'd0, fl}, 32'd0);
    read_b(rb);
    chk("abort_b", {16'd0, rb}, 32'h0);
    tick();
    chk("abort_ndone", {31'd0, ndone}, 32'd1);
    nreset = 1'b1;
    tick();
    chk("abort_idle_nstall", {31'd0, nstall}, 32'd1);

    // Uninterrupted ASR by 15
    write_b(16'h8000);
    set_l(1'b0);
    run_shift("asr15", 8'h2F, 16'hFFFF, 1'b0, 15);

    // Read during SHIFT shows intermediate B; commands and bus writes are ignored
    write_b(16'h0003);
    set_l(1'b0);
    e.b = 16'h000C; e.l = 1'b0; e.stalls = 2;
    sb.push_back(e);
    ir = 8'h02; naction_sru = 1'b0;
    tick();
    naction_sru = 1'b1;
    chk("mid_nstall0", {31'd0, nstall}, 32'd0);
    tick();
    chk("mid_nstall1", {31'd0, nstall}, 32'd0);
    read_b(rb);
    chk("mid_read_b", {16'd0, rb}, 32'h00000006);
    drv_en = 1'b1; drv_val = 16'h5A5A; nwrite_alu_b = 1'b0;
    naction_cpl = 1'b0; naction_sru = 1'b0;
    #1;
    chk("mid_bus_free", {16'd0, ibus}, 32'h00005A5A);
    tick();
    drv_en = 1'b0; nwrite_alu_b = 1'b1; naction_cpl = 1'b1; naction_sru = 1'b1;
    chk("mid_ndone", {31'd0, ndone}, 32'd0);
    got = sb.pop_front();
    read_b(rb);
    chk("mid_final_b", {16'd0, rb}, {16'd0, got.b});
    chk("mid_final_l", {31'd0, fl}, {31'd0, got.l});
    tick();
    chk("mid_idle_nstall", {31'd0, nstall}, 32'd1);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sru_sequencer.md
ALU_SRU_SEQUENCER -- requirements
Module: alu_sru_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the clock port named clk4 and the reset port named nreset.
REQ-002 Parameter WIDTH, default 16, SHALL set the B register and data bus width.
REQ-003 Parameter CNTW, default 4, SHALL set the shift-count field width.
REQ-004 clk4  in  1  clock; all state SHALL change on its rising edge.
REQ-005 nreset  in  1  asynchronous active-low reset.
REQ-006 nwrite_alu_b  in  1  active-low; loads B from ibus.
REQ-007 nread_alu_b  in  1  active-low; drives B onto ibus.
REQ-008 naction_cpl  in  1  active-low; complements L.
REQ-009 naction_cll  in  1  active-low; clears L.
REQ-010 naction_sru  in  1  active-low; starts a shift/rotate.
REQ-011 ir  in  8  instruction register; ir[6:4] is the mode and ir[3:0] is the count.
REQ-012 ibus  inout  WIDTH  data bus; SHALL be high-Z unless nread_alu_b=0.
REQ-013 fl  out  1  link flag L.
REQ-014 nstall  out  1  active-low; asserted while a shift is in progress.
REQ-015 ndone  out  1  active-low; one-cycle pulse when a shift completes.

Function
REQ-016 States SHALL be IDLE, SHIFT and DONE, encoded in 2 bits.
REQ-017 In IDLE, nwrite_alu_b=0 SHALL load B<=ibus.
REQ-018 In IDLE, naction_cll=0 SHALL set L<=0; if naction_cpl is also 0, cll SHALL take priority.
REQ-019 In IDLE, naction_cpl=0 alone SHALL set L<=~L.
REQ-020 In IDLE, naction_sru=0 with count!=0 and a valid mode SHALL latch mode and count, then go to SHIFT.
REQ-021 In IDLE, naction_sru=0 with count=0 or a reserved mode SHALL leave B and L unchanged, stay in IDLE, and not assert nstall.
REQ-022 If nwrite_alu_b=0 and naction_sru=0 in the same IDLE cycle, the write SHALL win and the shift SHALL be discarded.
REQ-023 In SHIFT, each cycle SHALL perform exactly one 1-bit step on {L,B} and decrement the counter.
REQ-024 In SHIFT with counter==1, the step SHALL be performed and the next state SHALL be DONE.
REQ-025 Mode 000 (SHL) SHALL give L<=B[msb], B<={B[msb-1:0],0}.
REQ-026 Mode 001 (SHR) SHALL give L<=B[0], B<={0,B[msb:1]}.
REQ-027 Mode 010 (ASR) SHALL give L<=B[0], B<={B[msb],B[msb:1]}.
REQ-028 Mode 011 (ROL) SHALL rotate the 17-bit value {L,B} left by one.
REQ-029 Mode 100 (ROR) SHALL rotate the 17-bit value {L,B} right by one.
REQ-030 Modes 101-111 SHALL be reserved.
REQ-031 nstall SHALL be a registered output, low exactly while state==SHIFT.
REQ-032 Latency: a count of N SHALL produce N SHIFT cycles, then 1 DONE cycle, then IDLE.
REQ-033 ndone SHALL be a registered output, low only in DONE; B and L SHALL hold their final values from DONE onward.
REQ-034 In SHIFT and DONE, nwrite_alu_b, naction_cpl, naction_cll and naction_sru SHALL be ignored.
REQ-035 nread_alu_b SHALL be honoured in every state and SHALL drive the current B value.
REQ-036 fl SHALL continuously reflect L.

Reset
REQ-037 With nreset=0: B=0, L=0, counter=0, mode=0, state=IDLE, nstall=1, ndone=1, and ibus high-Z (subject to nread_alu_b).
REQ-038 Reset asserted mid-SHIFT SHALL abort immediately, with no partial result retained.
REQ-039 After reset release, the first rising clk4 edge SHALL sample inputs normally.

Structure
REQ-040 Mode codes (SHL/SHR/ASR/ROL/ROR) and state encodings SHALL be defined in the shared ALU definitions header and reused by the microcode assembler tables.
REQ-041 The combinational 1-bit step {L,B,mode}->{L',B'} SHALL be a sub-module named alu_sru_step.
REQ-042 The counter SHALL be a CNTW-bit down-counter inside this block.

Verification
REQ-043 Reset then SHL: write B=16'h8001, L=0, then sru with ir=8'h01 -> nstall low 1 cycle, ndone pulse, B=16'h0002, L=1.
REQ-044 ROR by 4: B=16'h000F, L=0, ir=8'h44 -> 4 stall cycles, then B=16'hE000, L=1.
REQ-045 Count 0 and reserved mode: B=16'h1234, ir=8'h00 or ir=8'h53 -> nstall and ndone stay high, B and L unchanged.
REQ-046 Simultaneous events: nwrite_alu_b=0 (ibus=16'hAAAA) and naction_sru=0 in one cycle -> B=16'hAAAA and no stall; cpl and cll together -> L=0.
REQ-047 ASR by 15 from B=16'h8000, with reset asserted at stall cycle 7 -> immediately B=0, L=0, state IDLE, nstall=1; an uninterrupted run -> B=16'hFFFF, L=0.
REQ-048 Read during SHIFT: nread_alu_b=0 -> ibus shows the intermediate B; at all other times ibus is Z.
